round_arbiter: RTL
==================

# round_arbiter

Round-robin scheduler that shares one convergent-rounding datapath (W_IN → W_OUT, round-half-to-even) between N_CH requesters such as parallel FFT output lanes. Grants are held for up to BURST consecutive samples per channel, which keeps frame fragments contiguous. Results leave with their channel tag under valid/ready backpressure toward the postprocess output stage.

## Interface
- N_CH, 4: number of requesting channels (≥2).
- W_IN, 32: input sample width.
- W_OUT, 16: rounded output width (W_IN−W_OUT ≥ 2).
- BURST, 4: maximum consecutive grants to one channel (≥1; 1 = pure round-robin).
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- i_data  in  N_CH×W_IN: per-channel sample, packed with ch0 in the LSBs.
- i_vld  in  N_CH: per-channel valid.
- o_rdy  out  N_CH: per-channel ready. At most one bit is set per cycle. A transfer on channel c occurs when i_vld[c] && o_rdy[c].
- o_data  out  W_OUT: rounded sample.
- o_ch  out  $clog2(N_CH): source channel of o_data.
- o_vld  out  1: output valid.
- i_rdy  in  1: downstream ready. The output transfers when o_vld && i_rdy.

## Operation
- Pipeline: S1 (grant/capture register: data, channel, valid) → S2 (rounding register: o_data, o_ch, o_vld).
- Advance condition: adv = !o_vld || i_rdy.
  - When adv = 0, both stages hold.
  - When adv = 1 and S1 is empty, it is a bubble; S2 loads S1 regardless.
- Rounding in S2, with k = W_IN−W_OUT: o_data = (x + 2^(k−1) − 1 + x[k]) >> k, truncated to W_OUT bits.
  - Ties round to even.
  - Overflow wraps and does not saturate.
  - The operand is treated as unsigned bit pattern; two's-complement results are consistent.
- Arbiter FSM with states IDLE and LOCK, round-robin pointer ptr, and burst counter cnt.
  - IDLE: on adv, grant the first c with i_vld[c], searching from ptr upward with wrap.
    - If BURST>1: go to LOCK with owner=c, cnt=1.
    - If BURST=1: set ptr=c+1 mod N_CH and stay in IDLE.
  - LOCK: on adv with i_vld[owner], grant owner and increment cnt.
    - When cnt reaches BURST, set ptr=owner+1 and go to IDLE.
  - LOCK: on adv with !i_vld[owner], grant nothing this cycle, set ptr=owner+1, go to IDLE. The release costs one bubble cycle.
  - When adv = 0: no grant; FSM, ptr and cnt hold.
- o_rdy[c] = adv && (granted channel == c). It is combinational from the FSM state, i_vld and i_rdy; it has no combinational dependency on i_data.
- A channel that is not granted must see o_rdy low and keep its data stable (requester-side rule).

## Timing
- Reset values: o_vld=0, o_data=0, o_ch=0, o_rdy=0, S1 valid=0, FSM=IDLE, ptr=0, cnt=0.
- Latency: a sample transferred at edge t appears with o_vld at edge t+2 when no backpressure occurs.
- Throughput: 1 sample/cycle while requesters stay valid and i_rdy=1.
- Backpressure: while o_vld && !i_rdy, o_data and o_ch are stable, o_rdy is all-zero, and S1 holds. There is no loss and no duplication.
- Simultaneous requests: order is determined only by ptr. With all channels valid, BURST=4 and N_CH=4, the order is 0000 1111 2222 3333 0000…
- Burst boundary: after the BURST-th grant the next cycle is already in IDLE. The next channel is granted with no bubble.
- Reset mid-operation: S1/S2 contents are discarded, o_vld drops asynchronously, and in-flight samples are lost. After release the first grant goes to the lowest valid channel.

## Structure
- Package round_pkg:
  - arb_state_t enum {IDLE, LOCK}.
  - Function conv_round(x) parameterised by W_IN/W_OUT.
  - Localparam CH_W = $clog2(N_CH).
- Sub-module round_stage: the S2 register with convergent rounding, enable=adv, and the channel tag carried alongside the data.
- round_arbiter contains the FSM, the rotating priority encoder, the S1 register, and round_stage.

## Test plan
- Single channel (N_CH=4, W 32→16, BURST=4): ch2 sends 0x0001_8000, 0x0002_8000, 0x0002_8001, 0x0002_7FFF, 0xFFFF_8000 → o_data 0x0002, 0x0002, 0x0003, 0x0002, 0x0000, all with o_ch=2, each 2 cycles after its transfer.
- All four channels continuously valid, i_rdy=1 → o_ch sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0… and o_vld stays high after the fill.
- Early release: ch1 drops valid after 2 grants while ch3 is valid → one bubble cycle, then ch3 is granted; ptr was 2 at the search.
- Backpressure: i_rdy low for 5 cycles mid-stream → o_data/o_ch frozen, o_rdy=0, and the full sequence is delivered intact afterwards.
- BURST=1, ch0 and ch1 valid → strict alternation 0,1,0,1; never two consecutive o_ch equal.
- Async reset asserted mid-burst between edges → o_vld=0 immediately. After release with only ch3 valid, the first output is ch3 at +2 cycles.

Source files
------------

// File: rtl/round_pkg.sv
// Shared types and the convergent-rounding helper for the round-robin rounding arbiter.
package round_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int N_CH_DEF = 4;
    localparam int CH_W     = $clog2(N_CH_DEF);

    // Round-half-to-even: drop k LSBs with bias 2^(k-1)-1 plus the surviving LSB.
    // Caller zero-extends the operand and truncates the result, so overflow wraps.
    function automatic logic [63:0] conv_round(input logic [63:0] x, input logic [5:0] k);
        logic [63:0] bias;
        bias = (64'd1 << (k - 6'd1)) - 64'd1 + {63'd0, x[k]};
        return (x + bias) >> k;
    endfunction

endpackage

// File: rtl/round_stage.sv
// Output register: convergent rounding of the captured sample plus its channel tag and valid.
module round_stage
    import round_pkg::*;
#(
    parameter int W_IN    = 32,
    parameter int W_OUT   = 16,
    parameter int CH_BITS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [W_IN-1:0]    s1_data,
    input  logic [CH_BITS-1:0] s1_ch,
    input  logic               s1_vld,
    output logic [W_OUT-1:0]   o_data,
    output logic [CH_BITS-1:0] o_ch,
    output logic               o_vld
);

    localparam logic [5:0] K = 6'(W_IN - W_OUT);

    logic [W_OUT-1:0]   data_q, data_d;
    logic [CH_BITS-1:0] ch_q, ch_d;
    logic               vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        ch_d   = ch_q;
        vld_d  = vld_q;
        if (en) begin
            data_d = W_OUT'(conv_round(64'(s1_data), K));
            ch_d   = s1_ch;
            vld_d  = s1_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ch_q   <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            ch_q   <= ch_d;
            vld_q  <= vld_d;
        end
    end

    assign o_data = data_q;
    assign o_ch   = ch_q;
    assign o_vld  = vld_q;

endmodule

// File: rtl/round_arbiter.sv
// Round-robin burst arbiter feeding a shared convergent-rounding stage under valid/ready.
module round_arbiter
    import round_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W_IN  = 32,
    parameter int W_OUT = 16,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*W_IN-1:0]     i_data,
    input  logic [N_CH-1:0]          i_vld,
    output logic [N_CH-1:0]          o_rdy,
    output logic [W_OUT-1:0]         o_data,
    output logic [$clog2(N_CH)-1:0]  o_ch,
    output logic                     o_vld,
    input  logic                     i_rdy
);

    localparam int SEL_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(BURST + 1);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              adv;
    logic              hit_vld;
    logic [SEL_W-1:0]  hit_ch;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt_ch;
    logic [W_IN-1:0]   lane [N_CH];
    logic [W_IN-1:0]   s1_data_q, s1_data_d;
    logic [SEL_W-1:0]  s1_ch_q, s1_ch_d;
    logic              s1_vld_q, s1_vld_d;

    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
        return (int'(c) == N_CH - 1) ? '0 : c + SEL_W'(1);
    endfunction

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        assign lane[g] = i_data[g*W_IN +: W_IN];
    end

    assign adv = !o_vld || i_rdy;

    // Rotating priority encoder: first valid channel at or after ptr, with wrap.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_sel;
        hit_vld = 1'b0;
        hit_ch  = '0;
        idx     = 0;
        idx_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            idx_sel = SEL_W'(idx);
            if (!hit_vld && i_vld[idx_sel]) begin
                hit_vld = 1'b1;
                hit_ch  = idx_sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        if (rst_n && adv) begin
            case (state_q)
                IDLE: begin
                    if (hit_vld) begin
                        gnt_vld = 1'b1;
                        gnt_ch  = hit_ch;
                        if (BURST > 1) begin
                            state_d = LOCK;
                            owner_d = hit_ch;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            ptr_d = next_ch(hit_ch);
                        end
                    end
                end
                LOCK: begin
                    if (i_vld[owner_q]) begin
                        gnt_vld = 1'b1;
                        gnt_ch  = owner_q;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(BURST)) begin
                            ptr_d   = next_ch(owner_q);
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        // Owner went idle: this cycle is the release bubble.
                        ptr_d   = next_ch(owner_q);
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_rdy = '0;
        if (gnt_vld) o_rdy[gnt_ch] = 1'b1;
    end

    always_comb begin
        s1_data_d = s1_data_q;
        s1_ch_d   = s1_ch_q;
        s1_vld_d  = s1_vld_q;
        if (adv) begin
            s1_data_d = lane[gnt_ch];
            s1_ch_d   = gnt_ch;
            s1_vld_d  = gnt_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            s1_ch_q  <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            s1_ch_q  <= s1_ch_d;
            s1_vld_q <= s1_vld_d;
        end
    end

    // Sample payload is qualified by s1_vld_q and needs no reset.
    always_ff @(posedge clk) begin
        s1_data_q <= s1_data_d;
    end

    round_stage #(
        .W_IN   (W_IN),
        .W_OUT  (W_OUT),
        .CH_BITS(SEL_W)
    ) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (adv),
        .s1_data(s1_data_q),
        .s1_ch  (s1_ch_q),
        .s1_vld (s1_vld_q),
        .o_data (o_data),
        .o_ch   (o_ch),
        .o_vld  (o_vld)
    );

endmodule
